// File: rtl/f_adders_pkg.sv
// Shared constants for the f_adders ripple-carry adder family.
package f_adders_pkg;

   localparam int F_ADDERS_MAX_WIDTH     = 64;
   localparam int F_ADDERS_DEFAULT_WIDTH = 1;

endpackage : f_adders_pkg

// File: rtl/f_adder_cell.sv
// One-bit full adder cell: s = a ^ b ^ cin, cout = majority(a, b, cin).
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module f_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   // Propagate term is shared between the sum and the carry.
   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule : f_adder_cell

// File: rtl/f_adders.sv
// Registered ripple-carry adder {carry_out, sum} = a + b + carry_in; F_ADDERS_OVERFLOW_EN adds signed overflow.
// Latency: 1 cycle from a sampled in_valid edge; out_valid pulses for that one cycle.
// Backpressure: none, results must be taken in their out_valid cycle; outputs hold while in_valid=0.
module f_adders
   import f_adders_pkg::*;
#(
   parameter int WIDTH = F_ADDERS_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
`ifdef F_ADDERS_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   if (WIDTH < 1 || WIDTH > F_ADDERS_MAX_WIDTH) begin : g_bad_width
      $error("f_adders: WIDTH out of range 1..64");
   end

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;

   assign carry[0] = carry_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      f_adder_cell u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (sum_comb[i]),
         .cout (carry[i+1])
      );
   end

   // Result registers only load on a valid edge, so operand X/Z while idle never reaches them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum       <= sum_comb;
            carry_out <= carry[WIDTH];
         end
      end
   end

`ifdef F_ADDERS_OVERFLOW_EN
   // Signed overflow: carry into the MSB differs from carry out of it (carry[0] is carry_in for WIDTH=1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (in_valid) begin
         overflow <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end
`endif

endmodule : f_adders

// File: tb/tb_f_adders.sv
// Directed self-checking bench for f_adders at WIDTH=1, 8 and 16 (overflow checks when F_ADDERS_OVERFLOW_EN is defined).
module tb_f_adders;

   logic clk;
   logic rst_n;

   logic        iv1, a1, b1, cin1, ov1, s1, co1;
   logic        iv8, cin8, ov8, co8;
   logic [7:0]  a8, b8, s8;
   logic        iv16, cin16, ov16, co16;
   logic [15:0] a16, b16, s16;
`ifdef F_ADDERS_OVERFLOW_EN
   logic        ovf1, ovf8, ovf16;
`endif

   int checks = 0;
   int errors = 0;

   f_adders #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .carry_in(cin1),
`ifdef F_ADDERS_OVERFLOW_EN
      .overflow(ovf1),
`endif
      .out_valid(ov1), .sum(s1), .carry_out(co1)
   );

   f_adders #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .carry_in(cin8),
`ifdef F_ADDERS_OVERFLOW_EN
      .overflow(ovf8),
`endif
      .out_valid(ov8), .sum(s8), .carry_out(co8)
   );

   f_adders #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16), .carry_in(cin16),
`ifdef F_ADDERS_OVERFLOW_EN
      .overflow(ovf16),
`endif
      .out_valid(ov16), .sum(s16), .carry_out(co16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are then stable for checking and inputs may change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      iv1 = 0; a1 = 0; b1 = 0; cin1 = 0;
      iv8 = 0; a8 = 0; b8 = 0; cin8 = 0;
      iv16 = 0; a16 = 0; b16 = 0; cin16 = 0;
      #2;
      checks++;
      if (ov1 !== 1'b0 || s1 !== 1'b0 || co1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_w1 got v=%b s=%b c=%b want 0 0 0", ov1, s1, co1);
      end
      checks++;
      if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_w8 got v=%b s=%h c=%b want 0 00 0", ov8, s8, co8);
      end
      checks++;
      if (ov16 !== 1'b0 || s16 !== 16'h0000 || co16 !== 1'b0) begin
         errors++;
         $display("FAIL reset_w16 got v=%b s=%h c=%b want 0 0000 0", ov16, s16, co16);
      end
`ifdef F_ADDERS_OVERFLOW_EN
      checks++;
      if (ovf8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf got %b want 0", ovf8);
      end
`endif
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_exhaustive_w1();
      logic [7:0] exp_s;
      logic [7:0] exp_c;
      logic [2:0] vec;
      exp_s = 8'b1001_0110;
      exp_c = 8'b1110_1000;
      for (int i = 0; i < 8; i++) begin
         vec = 3'(i);
         {a1, b1, cin1} = vec;
         iv1 = 1'b1;
         tick();
         checks++;
         if (s1 !== exp_s[i] || co1 !== exp_c[i] || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL w1_vec%0d got s=%b c=%b v=%b want s=%b c=%b v=1",
                     i, s1, co1, ov1, exp_s[i], exp_c[i]);
         end
      end
      iv1 = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] av [3];
      logic [7:0] bv [3];
      logic       cv [3];
      logic [8:0] ev [3];
      av = '{8'hFF, 8'hFF, 8'hFF};
      bv = '{8'h01, 8'hFF, 8'h00};
      cv = '{1'b0, 1'b1, 1'b1};
      ev = '{9'h100, 9'h1FF, 9'h100};
      for (int i = 0; i < 3; i++) begin
         a8 = av[i]; b8 = bv[i]; cin8 = cv[i]; iv8 = 1'b1;
         tick();
         checks++;
         if ({co8, s8} !== ev[i] || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL wrap%0d got c=%b s=%h v=%b want c=%b s=%h v=1",
                     i, co8, s8, ov8, ev[i][8], ev[i][7:0]);
         end
      end
      iv8 = 1'b0;
   endtask

   task automatic test_hold();
      a8 = 8'h02; b8 = 8'h03; cin8 = 1'b0; iv8 = 1'b1;
      tick();
      checks++;
      if (s8 !== 8'h05 || co8 !== 1'b0 || ov8 !== 1'b1) begin
         errors++;
         $display("FAIL hold_load got s=%h c=%b v=%b want 05 0 1", s8, co8, ov8);
      end
      iv8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (s8 !== 8'h05 || co8 !== 1'b0 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL hold_cyc%0d got s=%h c=%b v=%b want 05 0 0", i, s8, co8, ov8);
         end
      end
      a8 = 'x; b8 = 'x; cin8 = 1'bx;
      tick();
      checks++;
      if (s8 !== 8'h05 || co8 !== 1'b0 || ov8 !== 1'b0) begin
         errors++;
         $display("FAIL hold_x got s=%h c=%b v=%b want 05 0 0", s8, co8, ov8);
      end
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
   endtask

   task automatic test_async_reset();
      // sum still holds 0x05; queue a valid operand that the reset must discard
      a8 = 8'h40; b8 = 8'h01; cin8 = 1'b0; iv8 = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (s8 !== 8'h00 || co8 !== 1'b0 || ov8 !== 1'b0) begin
         errors++;
         $display("FAIL async_rst got s=%h c=%b v=%b want 00 0 0", s8, co8, ov8);
      end
      tick();
      iv8 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (s8 !== 8'h00 || co8 !== 1'b0 || ov8 !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_idle got s=%h c=%b v=%b want 00 0 0", s8, co8, ov8);
      end
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; iv8 = 1'b1;
      tick();
      checks++;
      if (s8 !== 8'h30 || co8 !== 1'b0 || ov8 !== 1'b1) begin
         errors++;
         $display("FAIL post_rst_add got s=%h c=%b v=%b want 30 0 1", s8, co8, ov8);
      end
      iv8 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp;
      for (int i = 0; i < 16; i++) begin
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         cin16 = 1'($urandom_range(0, 1));
         if (i == 0) begin
            a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
         end
         exp = {1'b0, a16} + {1'b0, b16} + {16'h0000, cin16};
         iv16 = 1'b1;
         tick();
         checks++;
         if ({co16, s16} !== exp || ov16 !== 1'b1) begin
            errors++;
            $display("FAIL b2b%0d got c=%b s=%h v=%b want c=%b s=%h v=1",
                     i, co16, s16, ov16, exp[16], exp[15:0]);
         end
      end
      iv16 = 1'b0;
      tick();
      checks++;
      if (ov16 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain got v=%b want 0", ov16);
      end
   endtask

`ifdef F_ADDERS_OVERFLOW_EN
   task automatic test_overflow();
      logic [7:0] av [3];
      logic [7:0] bv [3];
      logic [7:0] es [3];
      logic       ec [3];
      logic       eo [3];
      av = '{8'h7F, 8'h80, 8'h01};
      bv = '{8'h01, 8'h80, 8'h01};
      es = '{8'h80, 8'h00, 8'h02};
      ec = '{1'b0, 1'b1, 1'b0};
      eo = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         a8 = av[i]; b8 = bv[i]; cin8 = 1'b0; iv8 = 1'b1;
         tick();
         checks++;
         if (s8 !== es[i] || co8 !== ec[i] || ovf8 !== eo[i]) begin
            errors++;
            $display("FAIL ovf%0d got s=%h c=%b o=%b want s=%h c=%b o=%b",
                     i, s8, co8, ovf8, es[i], ec[i], eo[i]);
         end
      end
      // WIDTH=1: 1+0+1 carries out with carry_in=1, so overflow = 1 ^ 1 = 0; 1+1+0 gives 1 ^ 0 = 1
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; iv1 = 1'b1;
      tick();
      checks++;
      if (ovf1 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_w1a got %b want 0", ovf1);
      end
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
      tick();
      checks++;
      if (ovf1 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_w1b got %b want 1", ovf1);
      end
      iv1 = 1'b0; iv8 = 1'b0;
      tick();
      checks++;
      if (ovf8 !== 1'b0 || ovf1 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_hold got o8=%b o1=%b want 0 1", ovf8, ovf1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_exhaustive_w1();
      test_wrap();
      test_hold();
      test_async_reset();
      test_back_to_back();
`ifdef F_ADDERS_OVERFLOW_EN
      test_overflow();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_f_adders
